// File: rtl/cpu_pkg.sv
// Shared types and constants for the register-file sequencer and its decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG
  } state_t;

  // Opcode field IR[15:13]
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // Op field IR[12:11] under OP_MOV
  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;

  // Op field IR[12:11] under OP_ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // Field positions (LSB of each field)
  localparam int OPCODE_LSB = 13;
  localparam int OP_LSB     = 11;
  localparam int RN_LSB     = 8;
  localparam int RD_LSB     = 5;
  localparam int SH_LSB     = 3;
  localparam int RM_LSB     = 0;
  localparam int IMM8_MSB   = 7;
  localparam int IMM5_MSB   = 4;

  // ALU instructions that need both A (Rn) and B (Rm) fetched
  function automatic logic is_two_operand(input logic [2:0] opcode, input logic [1:0] op);
    return (opcode == OP_ALU) && ((op == ALU_ADD) || (op == ALU_CMP) || (op == ALU_AND));
  endfunction

  // Instructions that only need B fetched (A is forced to zero or unused)
  function automatic logic is_b_only(input logic [2:0] opcode, input logic [1:0] op);
    return ((opcode == OP_MOV) && (op == MOV_REG)) || ((opcode == OP_ALU) && (op == ALU_MVN));
  endfunction

endpackage

// File: rtl/regfile_controller_if.sv
// Control/status bundle between the sequencer and the switch logic + datapath.
// Latency: n/a (wires only).
// Backpressure: none; the sequencer paces itself and reports idle on w.
interface regfile_controller_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  modport master (
    input  s, load, in,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );

  modport slave (
    output s, load, in,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/instr_decoder.sv
// Splits the instruction register into fields and sign-extends the immediates.
// Latency: combinational.
// Backpressure: none.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  assign opcode = ir[OPCODE_LSB +: 3];
  assign op     = ir[OP_LSB +: 2];
  assign rn     = ir[RN_LSB +: 3];
  assign rd     = ir[RD_LSB +: 3];
  assign sh     = ir[SH_LSB +: 2];
  assign rm     = ir[RM_LSB +: 3];

  assign sximm8 = {{8{ir[IMM8_MSB]}}, ir[IMM8_MSB:0]};
  assign sximm5 = {{11{ir[IMM5_MSB]}}, ir[IMM5_MSB:0]};

endmodule

// File: rtl/regfile_controller.sv
// Moore sequencer issuing register-file selects and datapath load strobes per instruction.
// Latency: 2 (undefined) / 3 (MOV imm) / 5 (MOV reg, MVN, CMP) / 6 (ADD, AND) edges from s to w.
// Backpressure: s and load are ignored while busy (w=0); the caller waits for w.
module regfile_controller
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_controller_if.master bus
);

  state_t      state;
  logic [15:0] ir;

  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [1:0]  sh;
  logic [2:0]  rm;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  // Registered Moore outputs: each is computed for the state being entered.
  logic        w_q;
  logic        write_q;
  logic        loada_q;
  logic        loadb_q;
  logic        loadc_q;
  logic        loads_q;
  logic        asel_q;
  logic        vsel_q;
  logic [2:0]  readnum_q;
  logic [2:0]  writenum_q;

  instr_decoder u_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm8 (sximm8),
    .sximm5 (sximm5)
  );

  // IR capture plus state sequencing; outputs are set for the next state so they
  // come straight from flops. IR only changes in WAIT, so the fields read here
  // are stable for the whole instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_WAIT;
      ir         <= 16'h0000;
      w_q        <= 1'b1;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= 1'b0;
      readnum_q  <= 3'd0;
      writenum_q <= 3'd0;
    end else begin
      w_q        <= 1'b0;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= 1'b0;
      readnum_q  <= 3'd0;
      writenum_q <= 3'd0;

      case (state)
        S_WAIT: begin
          if (bus.load) ir <= bus.in;
          if (bus.s) begin
            state <= S_DECODE;
          end else begin
            w_q <= 1'b1;
          end
        end

        S_DECODE: begin
          if ((opcode == OP_MOV) && (op == MOV_IMM)) begin
            state      <= S_WRITE_IMM;
            writenum_q <= rn;
            vsel_q     <= 1'b1;
            write_q    <= 1'b1;
          end else if (is_b_only(opcode, op)) begin
            state     <= S_GET_B;
            readnum_q <= rm;
            loadb_q   <= 1'b1;
          end else if (is_two_operand(opcode, op)) begin
            state     <= S_GET_A;
            readnum_q <= rn;
            loada_q   <= 1'b1;
          end else begin
            state <= S_WAIT;
            w_q   <= 1'b1;
          end
        end

        S_GET_A: begin
          state     <= S_GET_B;
          readnum_q <= rm;
          loadb_q   <= 1'b1;
        end

        S_GET_B: begin
          state  <= S_EXEC;
          // MOV reg computes 0 + shifted Rm, so A is forced to zero
          asel_q <= (opcode == OP_MOV);
          if ((opcode == OP_ALU) && (op == ALU_CMP)) begin
            loads_q <= 1'b1;
          end else begin
            loadc_q <= 1'b1;
          end
        end

        S_EXEC: begin
          if ((opcode == OP_ALU) && (op == ALU_CMP)) begin
            state <= S_WAIT;
            w_q   <= 1'b1;
          end else begin
            state      <= S_WRITE_REG;
            writenum_q <= rd;
            write_q    <= 1'b1;
          end
        end

        default: begin
          // S_WRITE_IMM and S_WRITE_REG both finish here
          state <= S_WAIT;
          w_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.w        = w_q;
  assign bus.write    = write_q;
  assign bus.loada    = loada_q;
  assign bus.loadb    = loadb_q;
  assign bus.loadc    = loadc_q;
  assign bus.loads    = loads_q;
  assign bus.asel     = asel_q;
  // The shifted B operand is always used; sximm5 is never selected by this ISA subset
  assign bus.bsel     = 1'b0;
  assign bus.vsel     = vsel_q;
  assign bus.readnum  = readnum_q;
  assign bus.writenum = writenum_q;
  assign bus.shift    = sh;
  assign bus.ALUop    = op;
  assign bus.sximm8   = sximm8;
  assign bus.sximm5   = sximm5;

endmodule

// File: tb/tb_regfile_controller.sv
// Directed bench for the register-file sequencer with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_controller;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   write_cnt;

  regfile_controller_if rf_if ();

  regfile_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle; counts write pulses seen
  task automatic step();
    @(posedge clk);
    #1;
    if (rf_if.write === 1'b1) write_cnt++;
  endtask

  function automatic logic [4:0] strobes();
    return {rf_if.write, rf_if.loada, rf_if.loadb, rf_if.loadc, rf_if.loads};
  endfunction

  // Load and start on the same edge; afterwards the FSM is in DECODE
  task automatic issue(input logic [15:0] word);
    rf_if.in   = word;
    rf_if.load = 1'b1;
    rf_if.s    = 1'b1;
    step();
    rf_if.load = 1'b0;
    rf_if.s    = 1'b0;
  endtask

  // Run an instruction to completion, bounded, gathering what was seen
  task automatic run_instr(input logic [15:0] word, output int edges, output int writes,
                           output logic [2:0] last_wnum, output logic [4:0] seen,
                           output logic asel_at_c);
    edges     = 0;
    seen      = 5'b0;
    last_wnum = 3'd0;
    asel_at_c = 1'b0;
    write_cnt = 0;
    issue(word);
    edges = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      edges++;
      seen = seen | strobes();
      if (rf_if.write) last_wnum = rf_if.writenum;
      if (rf_if.loadc) asel_at_c = rf_if.asel;
      if (rf_if.w) break;
    end
    writes = write_cnt;
  endtask

  int         edges;
  int         writes;
  logic [2:0] wnum;
  logic [4:0] seen;
  logic       asel_c;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    write_cnt = 0;
    reset = 1'b1;
    rf_if.s = 1'b0;
    rf_if.load = 1'b0;
    rf_if.in = 16'hFFFF;
    step();
    step();

    // Reset state
    chk("rst_w", rf_if.w, 1);
    chk("rst_strobes", strobes(), 0);
    chk("rst_readnum", rf_if.readnum, 0);
    chk("rst_writenum", rf_if.writenum, 0);
    chk("rst_sximm8", rf_if.sximm8, 0);
    chk("rst_sximm5", rf_if.sximm5, 0);
    reset = 1'b0;
    step();
    chk("idle_w", rf_if.w, 1);

    // MOV R1,#7: load first, then s on a later edge
    rf_if.in = 16'hD107;
    rf_if.load = 1'b1;
    step();
    rf_if.load = 1'b0;
    chk("d107_sximm8", rf_if.sximm8, 16'h0007);
    rf_if.s = 1'b1;
    step();                               // edge 1 -> DECODE
    rf_if.s = 1'b0;
    chk("d107_decode_w", rf_if.w, 0);
    chk("d107_decode_strobes", strobes(), 0);
    step();                               // edge 2 -> WRITE_IMM
    chk("d107_write", rf_if.write, 1);
    chk("d107_writenum", rf_if.writenum, 1);
    chk("d107_vsel", rf_if.vsel, 1);
    chk("d107_w_mid", rf_if.w, 0);
    step();                               // edge 3 -> WAIT
    chk("d107_w_end", rf_if.w, 1);
    chk("d107_strobes_end", strobes(), 0);

    // MOV R3,#-1
    run_instr(16'hD3FF, edges, writes, wnum, seen, asel_c);
    chk("d3ff_edges", edges, 3);
    chk("d3ff_writes", writes, 1);
    chk("d3ff_writenum", wnum, 3);
    chk("d3ff_sximm8", rf_if.sximm8, 16'hFFFF);
    chk("d3ff_sximm5", rf_if.sximm5, 16'hFFFF);

    // ADD R2,R1,R0 step by step
    write_cnt = 0;
    issue(16'hA140);
    chk("add_decode_strobes", strobes(), 0);
    step();
    chk("add_geta_loada", rf_if.loada, 1);
    chk("add_geta_readnum", rf_if.readnum, 1);
    step();
    chk("add_getb_loadb", rf_if.loadb, 1);
    chk("add_getb_readnum", rf_if.readnum, 0);
    step();
    chk("add_exec_loadc", rf_if.loadc, 1);
    chk("add_exec_loads", rf_if.loads, 0);
    chk("add_exec_aluop", rf_if.ALUop, 2'b00);
    chk("add_exec_asel", rf_if.asel, 0);
    chk("add_exec_bsel", rf_if.bsel, 0);
    step();
    chk("add_wr_write", rf_if.write, 1);
    chk("add_wr_writenum", rf_if.writenum, 2);
    chk("add_wr_vsel", rf_if.vsel, 0);
    chk("add_wr_w", rf_if.w, 0);
    step();                               // sixth edge
    chk("add_w_end", rf_if.w, 1);
    chk("add_writes", write_cnt, 1);

    // CMP R1,R0,LSL#1
    write_cnt = 0;
    issue(16'hA908);
    step();
    chk("cmp_geta_readnum", rf_if.readnum, 1);
    step();
    chk("cmp_getb_readnum", rf_if.readnum, 0);
    step();
    chk("cmp_exec_loads", rf_if.loads, 1);
    chk("cmp_exec_loadc", rf_if.loadc, 0);
    chk("cmp_exec_shift", rf_if.shift, 2'b01);
    chk("cmp_exec_aluop", rf_if.ALUop, 2'b01);
    step();                               // fifth edge
    chk("cmp_w_end", rf_if.w, 1);
    chk("cmp_writes", write_cnt, 0);

    // MVN R4,R2
    run_instr(16'hB882, edges, writes, wnum, seen, asel_c);
    chk("mvn_edges", edges, 5);
    chk("mvn_writes", writes, 1);
    chk("mvn_writenum", wnum, 4);
    chk("mvn_no_loada", seen[3], 0);
    chk("mvn_asel", asel_c, 0);

    // MOV R5,R3,LSR#1
    run_instr(16'hC0B3, edges, writes, wnum, seen, asel_c);
    chk("movr_edges", edges, 5);
    chk("movr_writenum", wnum, 5);
    chk("movr_asel", asel_c, 1);
    chk("movr_shift", rf_if.shift, 2'b10);

    // AND R6,R3,R1
    run_instr(16'hB3C1, edges, writes, wnum, seen, asel_c);
    chk("and_edges", edges, 6);
    chk("and_writes", writes, 1);
    chk("and_writenum", wnum, 6);
    chk("and_aluop", rf_if.ALUop, 2'b10);

    // Undefined opcodes
    run_instr(16'h0000, edges, writes, wnum, seen, asel_c);
    chk("undef0_edges", edges, 2);
    chk("undef0_strobes", seen, 0);
    run_instr(16'hC800, edges, writes, wnum, seen, asel_c);
    chk("undefc8_edges", edges, 2);
    chk("undefc8_strobes", seen, 0);

    // Reset during GET_B of an ADD
    write_cnt = 0;
    issue(16'hA140);
    step();
    step();
    chk("rstmid_in_getb", rf_if.loadb, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_w", rf_if.w, 1);
    chk("rstmid_sximm8", rf_if.sximm8, 0);
    chk("rstmid_strobes", strobes(), 0);
    for (int i = 0; i < 4; i++) step();
    chk("rstmid_no_write", write_cnt, 0);
    chk("rstmid_w_hold", rf_if.w, 1);

    // load with new word during EXEC must not disturb the IR
    issue(16'hA140);
    step();
    step();
    step();
    chk("ldexec_in_exec", rf_if.loadc, 1);
    rf_if.in = 16'hFFFF;
    rf_if.load = 1'b1;
    rf_if.s = 1'b1;
    step();
    chk("ldexec_sximm8", rf_if.sximm8, 16'h0040);
    chk("ldexec_writenum", rf_if.writenum, 2);
    rf_if.load = 1'b0;
    rf_if.s = 1'b0;
    step();
    chk("ldexec_w_end", rf_if.w, 1);
    chk("ldexec_sximm8_end", rf_if.sximm8, 16'h0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_controller.md
# regfile_controller

Moore-style sequencer that drives the 8×16 register file and its ALU datapath: it captures a 16-bit instruction, decodes it, and issues the per-cycle read/write selects and load strobes that move operands through the A/B/C/status registers and back into the register file. It sits between the top-level switch/input logic and the datapath, and is the only agent allowed to assert the register-file `write`.

## Interface
- No parameters. Widths are fixed by the datapath: 16-bit data, 3-bit register index.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `s` in 1: start pulse; sampled only in WAIT.
- `load` in 1: instruction-register enable; honoured only in WAIT.
- `in` in 16: instruction word.
- `w` out 1: 1 iff the FSM is in WAIT (idle, ready for a new instruction).
- `readnum` out 3: register-file read index.
- `writenum` out 3: register-file write index.
- `write` out 1: register-file write enable.
- `loada`, `loadb`, `loadc`, `loads` out 1 each: datapath A, B, C and status register enables.
- `asel`, `bsel` out 1 each: 1 selects zero / `sximm5` in place of A / shifted B.
- `vsel` out 1: write-back source; 0 = C, 1 = `sximm8`.
- `shift` out 2: shifter op, from IR[4:3].
- `ALUop` out 2: from IR[12:11].
- `sximm8` out 16: sign-extended IR[7:0].
- `sximm5` out 16: sign-extended IR[4:0].

## Operation
- Fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
- Supported: MOV Rn,#imm8 (110/10); MOV Rd,Rm{,sh} (110/00); ADD (101/00); CMP (101/01); AND (101/10); MVN (101/11). Anything else is undefined.
- The IR is internal and loads from `in` when `load`=1 in WAIT. `sximm8`, `sximm5`, `shift` and `ALUop` always reflect the IR.
- States and transitions:
  - WAIT: `s` -> DECODE.
  - DECODE: MOV imm -> WRITE_IMM; MOV reg or MVN -> GET_B; ADD, CMP or AND -> GET_A; undefined -> WAIT.
  - WRITE_IMM: `writenum`=Rn, `vsel`=1, `write`=1 -> WAIT.
  - GET_A: `readnum`=Rn, `loada`=1 -> GET_B.
  - GET_B: `readnum`=Rm, `loadb`=1 -> EXEC.
  - EXEC: `loadc`=1; `asel`=1 for MOV reg, else 0; `bsel`=0. CMP -> WAIT with `loads`=1 and `loadc`=0. All others -> WRITE_REG.
  - WRITE_REG: `writenum`=Rd, `vsel`=0, `write`=1 -> WAIT.
- MOV reg is A=0, ALUop=00, C = 0 + shifted Rm.
- Outputs are decoded from state and IR only, never from `s` or `load`.
- All strobes (`write`, `loada`, `loadb`, `loadc`, `loads`) are 0 in any state not listed above for them. `readnum` and `writenum` are 0 when unused.

## Timing
- Reset: state = WAIT, IR = 16'h0000, `w`=1, all strobes 0, `readnum`=`writenum`=0, `sximm8`=`sximm5`=0.
- Reset has priority over `s` and `load`. Reset asserted in any state returns the FSM to WAIT on that edge, and no write is issued afterwards.
- Latency, counted in edges from the edge sampling `s` to the return of `w`=1:
  - MOV imm: 3.
  - MOV reg, MVN, CMP: 5.
  - ADD, AND: 6.
  - Undefined opcode: 2.
- `s` and `load` outside WAIT are ignored; the IR is stable for the whole instruction.
- `s` and `load` together in WAIT: the IR updates and the FSM enters DECODE on the same edge, so DECODE sees the new IR.
- `write` is high for exactly one cycle per writing instruction.

## Structure
- Shared package `cpu_pkg`: state encoding enum, opcode/op constants (OP_MOV=3'b110, OP_ALU=3'b101, ALU_ADD/CMP/AND/MVN), field-position constants.
- One sub-module, `instr_decoder`: combinational field extraction and sign extension from the IR.
- IR register and FSM live in the top module.

## Test plan
- Reset, `load` with `in`=16'hD107, then `s`:
  - WRITE_IMM has `write`=1, `writenum`=1, `vsel`=1, `sximm8`=16'h0007.
  - `w`=1 three edges after `s`.
- `in`=16'hD3FF (MOV R3,#-1):
  - `sximm8`=16'hFFFF.
  - `write` pulses once with `writenum`=3.
- `in`=16'hA140 (ADD R2,R1,R0):
  - Sequence `loada`/`readnum`=1, then `loadb`/`readnum`=0, then `loadc` with `ALUop`=00, then `write`/`writenum`=2/`vsel`=0.
  - `w` back after 6 edges.
- `in`=16'hA908 (CMP R1,R0,LSL#1):
  - EXEC has `loads`=1, `shift`=01, `loadc`=0.
  - No `write` at any point; `w` back after 5 edges.
- Mid-operation hazards:
  - `reset` asserted during GET_B of an ADD: next cycle `w`=1, IR=0, no `write` ever asserted.
  - `load` with a new `in` during EXEC: IR unchanged.
- `in`=16'h0000 (undefined): DECODE -> WAIT in 2 edges, all strobes 0 throughout.
